// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared definitions for the sequential restoring divider:
//                controller state encoding, default operand widths, counter
//                width and the all-ones quotient returned for a zero divisor.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int c_N_W   = 8;
    localparam int c_D_W   = 4;
    localparam int c_CNT_W = $clog2(c_N_W);

    localparam logic [c_N_W-1:0] c_Q_ONES = {c_N_W{1'b1}};

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One purely combinational restoring-division step.
//                The trial value is the partial remainder shifted left with
//                the next dividend bit appended; it is compared against the
//                zero-extended divisor one bit wider than the operands, so the
//                compare never overflows.
//  Ports       : i_r       - partial remainder (low D_W bits)
//                i_bit     - next dividend bit, MSB first
//                i_divisor - divisor
//                o_r       - new partial remainder
//                o_q_bit   - resolved quotient bit
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import div_pkg::*;
#(
    parameter int D_W = c_D_W
) (
    input  logic [D_W-1:0] i_r,
    input  logic           i_bit,
    input  logic [D_W-1:0] i_divisor,
    output logic [D_W-1:0] o_r,
    output logic           o_q_bit
);

    logic [D_W:0] w_trial;

    always_comb begin
        w_trial = {i_r, i_bit};
        o_q_bit = (w_trial >= {1'b0, i_divisor});
        // When the subtract happens the result is below the divisor, so the
        // low D_W bits of the difference are the whole new remainder.
        o_r     = o_q_bit ? (w_trial[D_W-1:0] - i_divisor) : w_trial[D_W-1:0];
    end

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Multi-cycle unsigned restoring divider, one quotient bit per
//                clock, MSB first. go/done handshake; results are registered
//                and held until a new operation completes.
//  Ports       : clk100MHz   - system clock, rising edge
//                rst         - asynchronous active-low reset
//                go          - start request, sampled while ready=1
//                dividend    - N_W-bit numerator, captured on acceptance
//                divisor     - D_W-bit denominator, captured on acceptance
//                ready       - idle / able to accept go (IDLE or FIN)
//                busy        - iterations in progress
//                quotient    - registered N_W-bit result
//                remainder   - registered D_W-bit result
//                done        - one-cycle pulse, results valid
//                div_by_zero - zero-divisor flag, qualified by done
//  Config      : SEQ_DIVIDER_DZ_DETECT_EN - when defined, a zero divisor skips
//                the iterations and raises div_by_zero with done; otherwise
//                div_by_zero is tied low and every divisor runs full latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import div_pkg::*;
#(
    parameter int N_W = c_N_W,
    parameter int D_W = c_D_W
) (
    input  logic           clk100MHz,
    input  logic           rst,
    input  logic           go,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           ready,
    output logic           busy,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder,
    output logic           done,
    output logic           div_by_zero
);

    localparam int               CNT_W      = $clog2(N_W);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(N_W - 1);
    localparam logic [N_W-1:0]   c_ONES     = {N_W{1'b1}};

    state_t         r_state;
    state_t         w_state_nxt;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
    // after N_W steps this register holds the full quotient.
    logic [N_W-1:0] r_qsh;
    // Only the low D_W bits of the partial remainder are kept: the extra trial
    // bit is rebuilt each step inside div_step.
    logic [D_W-1:0] r_rem;
    logic [D_W-1:0] r_dvs;
    logic [CNT_W-1:0] r_cnt;

    logic           w_accept;
    logic           w_go_zero;
    logic [D_W-1:0] w_rem_nxt;
    logic           w_q_bit;

    div_step #(
        .D_W (D_W)
    ) u_step (
        .i_r       (r_rem),
        .i_bit     (r_qsh[N_W-1]),
        .i_divisor (r_dvs),
        .o_r       (w_rem_nxt),
        .o_q_bit   (w_q_bit)
    );

`ifdef SEQ_DIVIDER_DZ_DETECT_EN
    assign w_go_zero = (divisor == '0);
`else
    assign w_go_zero = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (go) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_go_zero ? FIN : ITER;
                end
            end
            ITER: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = FIN;
                end
            end
            FIN: begin
                // Accepting here lets a new operation overlap the result load.
                ready = 1'b1;
                if (go) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_go_zero ? FIN : ITER;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            r_qsh     <= '0;
            r_rem     <= '0;
            r_dvs     <= '0;
            r_cnt     <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            if (r_state == FIN) begin
                quotient  <= r_qsh;
                remainder <= r_rem;
                done      <= 1'b1;
            end

            if (r_state == ITER) begin
                r_rem <= w_rem_nxt;
                r_qsh <= {r_qsh[N_W-2:0], w_q_bit};
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_accept) begin
                r_dvs <= divisor;
                r_cnt <= c_CNT_LAST;
                if (w_go_zero) begin
                    // Same answer the full iteration would reach for a zero
                    // divisor, produced without iterating.
                    r_qsh <= c_ONES;
                    r_rem <= dividend[D_W-1:0];
                end else begin
                    r_qsh <= dividend;
                    r_rem <= '0;
                end
            end
        end
    end

`ifdef SEQ_DIVIDER_DZ_DETECT_EN
    logic r_dz_pend;
    logic r_dz;

    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            r_dz_pend <= 1'b0;
            r_dz      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dz_pend <= w_go_zero;
            end
            // A finishing result takes priority over the clear from a go
            // accepted on the same edge.
            if (r_state == FIN) begin
                r_dz <= r_dz_pend;
            end else if (w_accept) begin
                r_dz <= 1'b0;
            end
        end
    end

    assign div_by_zero = r_dz;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule : seq_divider
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Self-checking bench for seq_divider. Expected results come
//                from integer division and the division invariants; expected
//                timing comes from the documented request-to-done latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int N_W     = 8;
    localparam int D_W     = 4;
    localparam int LAT     = 10;
    localparam int TIMEOUT = 40;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
    localparam int   DZ_LAT  = 2;
    localparam logic DZ_FLAG = 1'b1;
`else
    localparam int   DZ_LAT  = 10;
    localparam logic DZ_FLAG = 1'b0;
`endif

    logic           clk100MHz = 1'b0;
    logic           rst;
    logic           go;
    logic [N_W-1:0] dividend;
    logic [D_W-1:0] divisor;
    logic           ready;
    logic           busy;
    logic [N_W-1:0] quotient;
    logic [D_W-1:0] remainder;
    logic           done;
    logic           div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(
        .N_W (N_W),
        .D_W (D_W)
    ) dut (
        .clk100MHz   (clk100MHz),
        .rst         (rst),
        .go          (go),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk100MHz = ~clk100MHz;

    task automatic tick();
        @(posedge clk100MHz);
        #1;
    endtask

    // Presents one request for a single cycle, scrambles the operand inputs
    // afterwards, and reports how many cycles after the request done rose
    // (-1 if it never did). Returns in the done cycle.
    task automatic run_op(input logic [N_W-1:0] a, input logic [D_W-1:0] b,
                          output int lat, output logic [N_W-1:0] q,
                          output logic [D_W-1:0] r, output logic dz);
        go       = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        go       = 1'b0;
        dividend = N_W'($urandom);
        divisor  = D_W'($urandom);
        lat      = 1;
        while (!done && lat < TIMEOUT) begin
            tick();
            lat++;
        end
        if (!done) lat = -1;
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        go       = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) tick();
        checks++;
        if ({quotient, remainder, done, div_by_zero, busy, ready} !== {12'h000, 4'b0001}) begin
            errors++;
            $display("FAIL reset_state: got q=%0d r=%0d done=%b dz=%b busy=%b ready=%b, want 0 0 0 0 0 1",
                     quotient, remainder, done, div_by_zero, busy, ready);
        end
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: got done=%b ready=%b, want 0 1", done, ready);
        end
    endtask

    task automatic test_basic();
        int lat; logic [N_W-1:0] q; logic [D_W-1:0] r; logic dz;
        go = 1'b1; dividend = 8'd200; divisor = 4'd7;
        tick();
        go = 1'b0;
        checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_accept: got busy=%b ready=%b, want 1 0", busy, ready);
        end
        lat = 1;
        while (!done && lat < TIMEOUT) begin tick(); lat++; end
        q = quotient; r = remainder; dz = div_by_zero;
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL latency_200_7: got %0d cycles, want %0d", lat, LAT);
        end
        checks++;
        if (q !== 8'd28 || r !== 4'd4 || dz !== 1'b0) begin
            errors++;
            $display("FAIL result_200_7: got q=%0d r=%0d dz=%b, want 28 4 0", q, r, dz);
        end
        tick();
        checks++;
        if (done !== 1'b0 || quotient !== 8'd28 || remainder !== 4'd4) begin
            errors++;
            $display("FAIL done_pulse_200_7: got done=%b q=%0d r=%0d, want 0 28 4", done, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int n; int m;
        go = 1'b1; dividend = 8'd255; divisor = 4'd15;
        tick();
        go = 1'b0;
        n = 1;
        while (n < LAT - 1) begin tick(); n++; end
        // Final cycle before the first result: the block must already accept.
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_before_done: got ready=%b done=%b, want 1 0", ready, done);
        end
        go = 1'b1; dividend = 8'd5; divisor = 4'd9;
        tick();
        go = 1'b0; dividend = 8'hFF; divisor = 4'd1;
        checks++;
        if (done !== 1'b1 || quotient !== 8'd17 || remainder !== 4'd0) begin
            errors++;
            $display("FAIL b2b_first: got done=%b q=%0d r=%0d, want 1 17 0", done, quotient, remainder);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_started: got busy=%b, want 1", busy);
        end
        m = 0;
        do begin tick(); m++; end while (!done && m < TIMEOUT);
        checks++;
        if (m !== LAT - 1) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles between dones, want %0d", m, LAT - 1);
        end
        checks++;
        if (quotient !== 8'd0 || remainder !== 4'd5) begin
            errors++;
            $display("FAIL b2b_second: got q=%0d r=%0d, want 0 5", quotient, remainder);
        end
        tick();
    endtask

    task automatic test_div_zero();
        int lat; logic [N_W-1:0] q; logic [D_W-1:0] r; logic dz;
        run_op(8'hA5, 4'd0, lat, q, r, dz);
        checks++;
        if (lat !== DZ_LAT) begin
            errors++;
            $display("FAIL dz_latency: got %0d cycles, want %0d", lat, DZ_LAT);
        end
        checks++;
        if (q !== 8'hFF || r !== 4'h5 || dz !== DZ_FLAG) begin
            errors++;
            $display("FAIL dz_result: got q=%h r=%h dz=%b, want ff 5 %b", q, r, dz, DZ_FLAG);
        end
        // The flag must drop once a normal operation completes.
        run_op(8'd9, 4'd2, lat, q, r, dz);
        checks++;
        if (q !== 8'd4 || r !== 4'd1 || dz !== 1'b0 || lat !== LAT) begin
            errors++;
            $display("FAIL dz_cleared: got q=%0d r=%0d dz=%b lat=%0d, want 4 1 0 %0d", q, r, dz, lat, LAT);
        end
        tick();
    endtask

    task automatic test_ignore_go();
        int n; int dones;
        go = 1'b1; dividend = 8'd100; divisor = 4'd3;
        tick();
        go = 1'b0;
        n = 1; dones = 0;
        while (n < LAT + 15) begin
            if (n >= 3 && n <= 6) begin
                go = 1'b1; dividend = N_W'($urandom); divisor = D_W'($urandom);
            end else begin
                go = 1'b0;
            end
            tick();
            n++;
            if (done) begin
                dones++;
                checks++;
                if (n !== LAT || quotient !== 8'd33 || remainder !== 4'd1) begin
                    errors++;
                    $display("FAIL ignore_go_result: got cycle=%0d q=%0d r=%0d, want %0d 33 1",
                             n, quotient, remainder, LAT);
                end
            end
        end
        checks++;
        if (dones !== 1 || busy !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL ignore_go_single: got dones=%0d busy=%b ready=%b, want 1 0 1", dones, busy, ready);
        end
    endtask

    task automatic test_reset_abort();
        int n; int dones; int lat; logic [N_W-1:0] q; logic [D_W-1:0] r; logic dz;
        go = 1'b1; dividend = 8'd77; divisor = 4'd4;
        tick();
        go = 1'b0;
        n = 1;
        while (n < 4) begin tick(); n++; end
        rst = 1'b0;
        #1;
        checks++;
        if ({quotient, remainder, done, div_by_zero, busy, ready} !== {12'h000, 4'b0001}) begin
            errors++;
            $display("FAIL abort_outputs: got q=%0d r=%0d done=%b dz=%b busy=%b ready=%b, want 0 0 0 0 0 1",
                     quotient, remainder, done, div_by_zero, busy, ready);
        end
        dones = 0;
        repeat (2) begin tick(); if (done) dones++; end
        rst = 1'b1;
        repeat (LAT + 4) begin tick(); if (done) dones++; end
        checks++;
        if (dones !== 0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_done: got dones=%0d ready=%b, want 0 1", dones, ready);
        end
        run_op(8'd77, 4'd4, lat, q, r, dz);
        checks++;
        if (q !== 8'd19 || r !== 4'd1 || lat !== LAT) begin
            errors++;
            $display("FAIL abort_fresh: got q=%0d r=%0d lat=%0d, want 19 1 %0d", q, r, lat, LAT);
        end
        tick();
    endtask

    task automatic test_sweep();
        int order [4096];
        int lat; logic [N_W-1:0] q; logic [D_W-1:0] r; logic dz;
        logic [N_W-1:0] a; logic [D_W-1:0] b;
        int bad;
        for (int i = 0; i < 4096; i++) order[i] = i;
        for (int i = 4095; i > 0; i--) begin
            int j; int t;
            j = int'($urandom_range(i, 0));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 4096; i++) begin
            a = N_W'(order[i] >> D_W);
            b = D_W'(order[i]);
            run_op(a, b, lat, q, r, dz);
            bad = 0;
            if (b != 0) begin
                if (int'(q) * int'(b) + int'(r) != int'(a) || r >= b || lat != LAT || dz !== 1'b0) bad = 1;
            end else begin
                if (q !== 8'hFF || r !== a[D_W-1:0] || lat != DZ_LAT || dz !== DZ_FLAG) bad = 1;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dz=%b lat=%0d", a, b, q, r, dz, lat);
            end
            repeat ($urandom_range(2, 0)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_ignore_go();
        test_reset_abort();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_divider
`default_nettype wire
